// File: rtl/hazard_pkg.sv
// Shared definitions for the RAW hazard unit and later forwarding logic:
// opcode encodings, scoreboard entry type and scoreboard depth.
// Optional build macro RF_BYPASS_EN (see raw_hazard_unit.sv).
package hazard_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_RTI   = 5'b00011;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_ALUR0 = 5'b11010;
  localparam logic [4:0] OP_ALUR1 = 5'b11011;
  localparam logic [2:0] OP_CMP_PFX = 3'b111;

  localparam int unsigned SB_DEPTH = 3;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/raw_hazard_unit_src_parser.sv
// Source-register parser: which register fields an instruction reads.
// Purely combinational; shared with any forwarding unit.
module src_parser
  import hazard_pkg::*;
(
  input  logic [15:0] instr,
  output logic        reads_rs,
  output logic        reads_rt,
  output logic [2:0]  rs,
  output logic [2:0]  rt
);

  logic [4:0] opcode;
  logic       unused_imm;

  assign opcode     = instr[15:11];
  assign rs         = instr[10:8];
  assign rt         = instr[7:5];
  assign unused_imm = ^instr[4:0];

  // Decode which source fields are real operands for this opcode
  always_comb begin
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    case (opcode)
      OP_HALT, OP_NOP, OP_SIIC, OP_RTI,
      OP_J, OP_JAL, OP_LBI: reads_rs = 1'b0;
      default:              reads_rs = 1'b1;
    endcase
    if (opcode == OP_ST || opcode == OP_STU ||
        opcode == OP_ALUR0 || opcode == OP_ALUR1 ||
        opcode[4:2] == OP_CMP_PFX)
      reads_rt = 1'b1;
  end

endmodule

// File: rtl/raw_hazard_unit.sv
// Read-after-write hazard detector with EX/MEM/WB write scoreboard and a
// saturating stall-cycle counter.
// Build macro RF_BYPASS_EN: register file forwards WB data, so the WB entry
// is excluded from the hazard compare (it is still shifted in both builds).
module raw_hazard_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_id,
  input  logic        valid_id,
  input  logic [2:0]  rd_id,
  input  logic        regwrt_id,
  input  logic        flush,
  output logic        stall,
  output logic [15:0] stall_cnt
);

`ifdef RF_BYPASS_EN
  localparam int unsigned CMP_DEPTH = SB_DEPTH - 1;
`else
  localparam int unsigned CMP_DEPTH = SB_DEPTH;
`endif

  sb_entry_t  sb [SB_DEPTH];
  logic       reads_rs, reads_rt;
  logic [2:0] rs, rt;
  logic       hit_rs, hit_rt, hazard;

  src_parser u_src_parser (
    .instr    (instr_id),
    .reads_rs (reads_rs),
    .reads_rt (reads_rt),
    .rs       (rs),
    .rt       (rt)
  );

`ifdef RF_BYPASS_EN
  logic unused_wb_entry;
  assign unused_wb_entry = ^sb[SB_DEPTH-1];
`endif

  // Compare decode sources against the in-flight writes that can still hazard
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int unsigned i = 0; i < CMP_DEPTH; i++) begin
      if (sb[i].valid && sb[i].rd == rs) hit_rs = 1'b1;
      if (sb[i].valid && sb[i].rd == rt) hit_rt = 1'b1;
    end
    hazard = valid_id & ((reads_rs & hit_rs) | (reads_rt & hit_rt));
    stall  = hazard & ~flush;
  end

  // Advance the scoreboard one stage per cycle and count stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
      if (stall || flush)
        sb[0] <= '0;
      else
        sb[0] <= sb_entry_t'{valid: valid_id & regwrt_id, rd: rd_id};
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_raw_hazard_unit.sv
// Self-checking bench for raw_hazard_unit: a reference scoreboard model
// queues the expected stall/stall_cnt per driven cycle, which are popped and
// compared when the DUT outputs settle. Honors RF_BYPASS_EN like the design.
module tb_raw_hazard_unit;

`ifdef RF_BYPASS_EN
  localparam int NCMP = 2;
  localparam int PAIR_STALL = 2;
`else
  localparam int NCMP = 3;
  localparam int PAIR_STALL = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr_id = '0;
  logic        valid_id = 1'b0;
  logic [2:0]  rd_id = '0;
  logic        regwrt_id = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  raw_hazard_unit dut (
    .clk       (clk),
    .rst       (rst),
    .instr_id  (instr_id),
    .valid_id  (valid_id),
    .rd_id     (rd_id),
    .regwrt_id (regwrt_id),
    .flush     (flush),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit stall; bit [15:0] cnt; } exp_t;
  exp_t exp_q[$];

  // reference model state
  bit       m_v  [3];
  bit [2:0] m_rd [3];
  bit [15:0] m_cnt = 0;
  bit       m_stall;
  bit       last_obs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic bit m_reads_rs(input bit [15:0] ins);
    bit [4:0] op = ins[15:11];
    return !(op == 5'b00000 || op == 5'b00001 || op == 5'b00010 || op == 5'b00011 ||
             op == 5'b00100 || op == 5'b00110 || op == 5'b11000);
  endfunction

  function automatic bit m_reads_rt(input bit [15:0] ins);
    bit [4:0] op = ins[15:11];
    return op == 5'b10000 || op == 5'b10011 || op == 5'b11011 || op == 5'b11010 ||
           op[4:2] == 3'b111;
  endfunction

  function automatic bit m_hit(input bit [2:0] r);
    bit h = 0;
    for (int i = 0; i < NCMP; i++) if (m_v[i] && m_rd[i] == r) h = 1;
    return h;
  endfunction

  function automatic bit [15:0] mk(input bit [4:0] op, input bit [2:0] rs, input bit [2:0] rt);
    return {op, rs, rt, 5'b00000};
  endfunction

  // one cycle: drive, queue expectation, compare at negedge, advance model
  task automatic step(input bit [15:0] ins, input bit v, input bit [2:0] rd,
                      input bit w, input bit fl, input bit r);
    exp_t e, got;
    bit hz;
    instr_id = ins; valid_id = v; rd_id = rd; regwrt_id = w; flush = fl; rst = r;
    hz = v && ((m_reads_rs(ins) && m_hit(ins[10:8])) || (m_reads_rt(ins) && m_hit(ins[7:5])));
    m_stall = hz && !fl;
    e.stall = m_stall; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("stall", {31'd0, stall}, {31'd0, got.stall});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, got.cnt});
    last_obs = stall;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_rd[i] = 0; end
      m_cnt = 0;
    end else begin
      m_v[2] = m_v[1]; m_rd[2] = m_rd[1];
      m_v[1] = m_v[0]; m_rd[1] = m_rd[0];
      m_v[0] = (m_stall || fl) ? 1'b0 : (v && w);
      m_rd[0] = (m_stall || fl) ? 3'd0 : rd;
      if (m_stall && m_cnt != 16'hFFFF) m_cnt++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0800, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // producer followed by a consumer held in decode while the model stalls
  task automatic pair(input bit [15:0] pi, input bit [2:0] prd, input bit pw,
                      input bit [15:0] ci, input bit [2:0] crd, output int n);
    n = 0;
    step(pi, 1'b1, prd, pw, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(ci, 1'b1, crd, 1'b1, 1'b0, 1'b0);
      if (last_obs) n++;
      if (!m_stall) break;
    end
  endtask

  initial begin
    int n;
    int guard;
    for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_rd[i] = 0; end
    @(posedge clk); #1;
    step(16'h0800, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(16'h0800, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(16'h0800, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);

    // ADD r1,r2,r3 -> ADD r4,r1,r5
    pair(mk(5'b11011, 3'd2, 3'd3), 3'd1, 1'b1, mk(5'b11011, 3'd1, 3'd5), 3'd4, n);
    chk("add_pair_stalls", n, PAIR_STALL);
    chk("add_pair_cnt", {16'd0, stall_cnt}, PAIR_STALL);
    idle(4);

    // LBI r1 -> ST r6,r1 (dependency through Rt)
    pair(mk(5'b11000, 3'd1, 3'd0), 3'd1, 1'b1, mk(5'b10000, 3'd6, 3'd1), 3'd0, n);
    chk("lbi_st_stalls", n, PAIR_STALL);
    idle(4);

    // ST r1 does not write -> ADD reading r1 does not stall
    pair(mk(5'b10000, 3'd2, 3'd1), 3'd1, 1'b0, mk(5'b11011, 3'd1, 3'd1), 3'd3, n);
    chk("st_nowrite_stalls", n, 0);
    idle(4);

    // LBI r2 -> J / NOP with r2 in the Rs field
    pair(mk(5'b11000, 3'd2, 3'd0), 3'd2, 1'b1, mk(5'b00100, 3'd2, 3'd2), 3'd0, n);
    chk("lbi_j_stalls", n, 0);
    idle(4);
    pair(mk(5'b11000, 3'd2, 3'd0), 3'd2, 1'b1, mk(5'b00001, 3'd2, 3'd2), 3'd0, n);
    chk("lbi_nop_stalls", n, 0);
    idle(4);

    // r0 is tracked; valid_id=0 never stalls
    step(mk(5'b11011, 3'd2, 3'd3), 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(mk(5'b11011, 3'd0, 3'd0), 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("bubble_no_stall", {31'd0, last_obs}, 32'd0);
    step(mk(5'b11011, 3'd0, 3'd7), 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    chk("r0_stall", {31'd0, last_obs}, 32'd1);
    idle(4);

    // flush during the first hazard cycle
    n = stall_cnt;
    step(mk(5'b11011, 3'd2, 3'd3), 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(mk(5'b11011, 3'd1, 3'd5), 1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
    chk("flush_stall", {31'd0, last_obs}, 32'd0);
    step(mk(5'b11011, 3'd4, 3'd4), 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    chk("flush_no_entry", {31'd0, last_obs}, 32'd0);
    chk("flush_cnt", {16'd0, stall_cnt}, n);
    idle(4);

    // reset during the second stall cycle
    step(mk(5'b11011, 3'd2, 3'd3), 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(mk(5'b11011, 3'd1, 3'd5), 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    step(mk(5'b11011, 3'd1, 3'd5), 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
    step(mk(5'b11011, 3'd1, 3'd5), 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_stall", {31'd0, last_obs}, 32'd0);
    chk("rst_mid_cnt", {16'd0, last_obs ? 16'hFFFF : 16'd0}, 32'd0);
    idle(4);
    chk("rst_cnt_zero", {16'd0, stall_cnt}, 32'd0);

`ifndef RF_BYPASS_EN
    // self-dependent stream drives the counter into saturation
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 90000) begin
      step(mk(5'b11011, 3'd1, 3'd1), 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    for (int i = 0; i < 8; i++)
      step(mk(5'b11011, 3'd1, 3'd1), 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    chk("cnt_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
